// File: rtl/cesar_shift_if.sv
// Handshake and data bundle for the cesar_shift Johnson-code digit shifter.
// The requester drives start/dir/key/din and watches busy/done/err/dout.
interface cesar_shift_if;
    logic       start;
    logic       dir;
    logic [3:0] key;
    logic [4:0] din;
    logic [4:0] dout;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, dir, key, din,
        input  dout, busy, done, err
    );

    modport slave (
        input  start, dir, key, din,
        output dout, busy, done, err
    );
endinterface

// File: rtl/cesar_shift.sv
// cesar_shift: Caesar-shifts one decimal digit held in a 5-bit, 10-state
// Johnson code by (key mod 10) positions, one position per clock.
// Optional feature: define CESAR_DECRYPT_EN to honour dir (backward shift);
// without it dir is ignored and every shift goes forward.
module cesar_shift (
    input  logic          clk,
    input  logic          rst,
    cesar_shift_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Legal Johnson codes, digit gi lives at bits [gi*5 +: 5].
    localparam logic [49:0] LEGAL_CODES = {
        5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
        5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000
    };

    state_t     state_reg, state_next;
    logic [4:0] r_reg, r_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       err_reg, err_next;
    logic       done_reg, done_next;

    logic [9:0] code_hit;
    logic       din_legal;
    logic [3:0] key_mod;
    logic [4:0] fwd_step;
    logic [4:0] step;
    logic       accept;

    // One comparator per legal code; din is legal if any of them matches.
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_legal
            assign code_hit[gi] = (bus.din == LEGAL_CODES[gi*5 +: 5]);
        end
    endgenerate

    assign din_legal = |code_hit;
    assign accept    = (state_reg == IDLE) && bus.start;

    // Keys 10..15 fold onto 0..5.
    assign key_mod  = (bus.key >= 4'd10) ? (bus.key - 4'd10) : bus.key;

    // Rotating the inverted end bit walks the ring one digit up.
    assign fwd_step = {~r_reg[0], r_reg[4:1]};

`ifdef CESAR_DECRYPT_EN
    logic       dir_reg;
    logic [4:0] bwd_step;

    assign bwd_step = {r_reg[3:0], ~r_reg[4]};
    assign step     = dir_reg ? bwd_step : fwd_step;

    // Direction is captured only when a request is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_reg <= 1'b0;
        end else if (accept) begin
            dir_reg <= bus.dir;
        end
    end
`else
    // dir stays on the interface but has no effect in the forward-only build.
    logic unused_dir;
    assign unused_dir = bus.dir;
    assign step       = fwd_step;
`endif

    // State and datapath registers; reset parks on digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            r_reg     <= 5'b10000;
            cnt_reg   <= 4'd0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            r_reg     <= r_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic: load on accept, step until the count runs out,
    // and bail out immediately on an illegal code.
    always_comb begin
        state_next = state_reg;
        r_next     = r_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    r_next     = bus.din;
                    cnt_next   = key_mod;
                    err_next   = ~din_legal;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if ((cnt_reg == 4'd0) || err_reg) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    r_next   = step;
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.dout = r_reg;
    assign bus.busy = (state_reg == SHIFT);
    assign bus.done = done_reg;
    assign bus.err  = err_reg;

endmodule

// File: tb/tb_cesar_shift.sv
// Directed bench for cesar_shift: a reference model based on decimal digits
// pushes expected results into a scoreboard when a request is driven; they
// are popped and compared when done pulses.
module tb_cesar_shift;

`ifdef CESAR_DECRYPT_EN
    localparam bit DECRYPT_EN = 1'b1;
`else
    localparam bit DECRYPT_EN = 1'b0;
`endif

    typedef struct {
        logic [4:0] dout;
        logic       err;
        int         lat;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    exp_t sb[$];

    cesar_shift_if bus ();

    cesar_shift dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Johnson code -> digit, -1 for illegal codes.
    function automatic int j2d(input logic [4:0] c);
        case (c)
            5'b10000: return 0;
            5'b11000: return 1;
            5'b11100: return 2;
            5'b11110: return 3;
            5'b11111: return 4;
            5'b01111: return 5;
            5'b00111: return 6;
            5'b00011: return 7;
            5'b00001: return 8;
            5'b00000: return 9;
            default:  return -1;
        endcase
    endfunction

    function automatic logic [4:0] d2j(input int dg);
        case (dg)
            0:       return 5'b10000;
            1:       return 5'b11000;
            2:       return 5'b11100;
            3:       return 5'b11110;
            4:       return 5'b11111;
            5:       return 5'b01111;
            6:       return 5'b00111;
            7:       return 5'b00011;
            8:       return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic exp_t model(input logic [4:0] d, input logic [3:0] k, input logic dr);
        exp_t m;
        int   dg;
        int   eff;
        bit   backward;
        dg       = j2d(d);
        eff      = int'(k) % 10;
        backward = dr && DECRYPT_EN;
        if (dg < 0) begin
            m.dout = d;
            m.err  = 1'b1;
            m.lat  = 0;
        end else begin
            m.err  = 1'b0;
            m.lat  = eff;
            m.dout = backward ? d2j((dg + 10 - eff) % 10) : d2j((dg + eff) % 10);
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request (called at a negedge), then watch until done.
    // poke >= 0 re-asserts start with other data that many cycles in.
    task automatic run_op(input string tag, input logic [4:0] d, input logic [3:0] k,
                          input logic dr, input int poke);
        exp_t e;
        int   busy_cnt;
        bit   got;
        sb.push_back(model(d, k, dr));
        bus.start = 1'b1;
        bus.din   = d;
        bus.key   = k;
        bus.dir   = dr;
        busy_cnt  = 0;
        got       = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (i == poke) begin
                bus.start = 1'b1;
                bus.din   = 5'b11111;
                bus.key   = 4'd1;
                bus.dir   = ~dr;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) got = 1'b1;
            else if (bus.busy) busy_cnt++;
        end
        e = sb.pop_front();
        check({tag, "/done_seen"}, 32'(got), 32'd1);
        check({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(e.lat + 1));
        check({tag, "/busy_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, "/dout"}, 32'(bus.dout), 32'(e.dout));
        check({tag, "/err"}, 32'(bus.err), 32'(e.err));
        $display("[TB] op %s din=%b key=%0d dir=%0d -> dout=%b err=%0d busy_cycles=%0d",
                 tag, d, k, dr, bus.dout, bus.err, busy_cnt);
    endtask

    // Leave start low for n cycles; outputs must hold with no done.
    task automatic idle_check(input string tag, input int n, input logic [4:0] exp_dout,
                              input logic exp_err);
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "/idle"}, {24'd0, bus.busy, bus.done, bus.err, bus.dout},
                  {24'd0, 1'b0, 1'b0, exp_err, exp_dout});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         done_pulses;
        int         dg;
        logic [3:0] rk;
        logic       rd;
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.dir   = 1'b0;
        bus.key   = 4'd0;
        bus.din   = 5'b00000;

        // Reset for one edge.
        @(negedge clk);
        rst = 1'b0;
        check("rst/dout", 32'(bus.dout), 32'h10);
        check("rst/busy", 32'(bus.busy), 32'd0);
        check("rst/done", 32'(bus.done), 32'd0);
        check("rst/err",  32'(bus.err),  32'd0);
        $display("[TB] reset dout=%b busy=%0d done=%0d err=%0d", bus.dout, bus.busy, bus.done, bus.err);

        // Main function; consecutive ops start on the previous done cycle.
        run_op("d0k3",      5'b10000, 4'd3,  1'b0, -1);
        run_op("d8k12",     5'b00001, 4'd12, 1'b0, -1);
        run_op("d1k3dir1",  5'b11000, 4'd3,  1'b1, -1);
        run_op("d5k15",     5'b01111, 4'd15, 1'b0, -1);
        run_op("d2k10",     5'b11100, 4'd10, 1'b1, -1);
        run_op("d0k1dir1",  5'b10000, 4'd1,  1'b1, -1);
        idle_check("hold", 4, model(5'b10000, 4'd1, 1'b1).dout, 1'b0);

        // Illegal code: no steps, err held until the next accepted start.
        run_op("illegal",   5'b10101, 4'd5,  1'b0, -1);
        idle_check("errhold", 3, 5'b10101, 1'b1);
        run_op("clear_err", 5'b11111, 4'd0,  1'b0, -1);

        // start re-pulsed mid-SHIFT is ignored.
        run_op("poke",      5'b10000, 4'd7,  1'b0, 3);

        // Random legal traffic.
        for (int n = 0; n < 6; n++) begin
            dg = int'($urandom_range(0, 9));
            rk = 4'($urandom_range(0, 15));
            rd = 1'($urandom_range(0, 1));
            run_op("rand", d2j(dg), rk, rd, -1);
        end

        // Reset in the middle of a shift: back to digit 0, no done pulse.
        bus.start = 1'b1;
        bus.din   = 5'b11100;
        bus.key   = 4'd9;
        bus.dir   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst/dout", 32'(bus.dout), 32'h10);
        check("midrst/busy", 32'(bus.busy), 32'd0);
        check("midrst/done", 32'(bus.done), 32'd0);
        check("midrst/err",  32'(bus.err),  32'd0);
        done_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) done_pulses++;
        end
        check("midrst/no_done", 32'(done_pulses), 32'd0);
        $display("[TB] reset mid-shift dout=%b done_pulses=%0d", bus.dout, done_pulses);

        run_op("after_rst", 5'b00111, 4'd4, 1'b0, -1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cesar_shift.md
CESAR_SHIFT -- requirements
Module: cesar_shift

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port: start  input  1  request to encode one digit; sampled only in IDLE.
REQ-004 SHALL have port: dir  input  1  0 = encrypt (forward shift), 1 = decrypt (backward shift).
REQ-005 SHALL have port: key  input  4  shift amount; 0-15, taken modulo 10.
REQ-006 SHALL have port: din  input  5  input digit in 10-state Johnson code; din[4]..din[0] = s5..s1.
REQ-007 SHALL have port: dout  output  5  shifted digit in the same Johnson code; drives the Johnson-to-7-segment decoder s5..s1 directly.
REQ-008 SHALL have port: busy  output  1  high while shifting.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when dout holds the final result.
REQ-010 SHALL have port: err  output  1  high when the last accepted din was not a legal code.

Function
REQ-011 SHALL treat exactly these 10 codes as legal, for digits 0-9: 10000, 11000, 11100, 11110, 11111, 01111, 00111, 00011, 00001, 00000.
REQ-012 SHALL implement forward step R <= {~R[0], R[4:1]} (digit d -> (d+1) mod 10, 9 wraps to 0).
REQ-013 SHALL implement backward step R <= {R[3:0], ~R[4]} (digit d -> (d+9) mod 10, 0 wraps to 9).
REQ-014 SHALL use states IDLE and SHIFT only; busy = (state == SHIFT); dout = R at all times.
REQ-015 SHALL, in IDLE with start=1, load R <= din, cnt <= key mod 10 (keys 10-15 map to 0-5), latch dir, set err <= (din illegal), and enter SHIFT.
REQ-016 SHALL, in SHIFT with cnt != 0 and err = 0, apply one step per cycle in the latched direction and decrement cnt.
REQ-017 SHALL, in SHIFT with cnt = 0 or err = 1, return to IDLE and assert done for exactly that one cycle.
REQ-018 SHALL have a latency of k+1 cycles: with effective key k, start is accepted at edge 0, busy is high for k+1 cycles, and done is high in the cycle after edge k+1.
REQ-019 SHALL ignore start while busy; no state, counter or direction change.
REQ-020 SHALL, on an illegal din, perform no steps, hold dout = din unchanged, and keep err high until the next accepted start.
REQ-021 SHALL hold dout stable in IDLE until the next accepted start.
REQ-022 SHALL treat start asserted on the done cycle as a new accepted request, since the FSM is then back in IDLE.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, set state IDLE, R = 10000 (digit 0), cnt = 0, busy = 0, done = 0, err = 0.
REQ-024 SHALL give rst priority over start and over an in-progress SHIFT; the aborted operation produces no done pulse.

Configuration
REQ-025 SHALL, with CESAR_DECRYPT_EN defined, honour dir per REQ-013.
REQ-026 SHALL, without CESAR_DECRYPT_EN, keep the dir port but ignore it, always stepping forward; the backward-step logic is not synthesized.

Verification
REQ-027 SHALL cover: rst=1 for one edge -> dout=10000, busy=0, done=0, err=0.
REQ-028 SHALL cover: din=10000, key=3, dir=0, start pulse -> busy high 4 cycles, then done pulse with dout=11110 (digit 3).
REQ-029 SHALL cover: din=00001 (8), key=12, dir=0 -> effective key 2, wraps through 9 -> dout=10000 (0); done 3 cycles after start.
REQ-030 SHALL cover: CESAR_DECRYPT_EN defined, din=11000 (1), key=3, dir=1 -> dout=00001 (8); the same stimulus without the macro -> dout=11111 (4).
REQ-031 SHALL cover: din=10101, key=5 -> err=1, done in the cycle after the start edge, dout=10101; a following legal start clears err.
REQ-032 SHALL cover: start re-pulsed mid-SHIFT -> ignored and result unchanged; rst during SHIFT -> IDLE, dout=10000, no done pulse.
